// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter and runs the
// req/ack fetch from instruction memory and the valid/ready hand-off to decode.
module fetch_stage #(
    parameter int unsigned             PC_WIDTH    = 8,
    parameter int unsigned             INSTR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PC_WIDTH-1:0]    next_pc,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [7:0]             fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t state;

    // The request address is the pc itself; pc only moves on retire,
    // so the address cannot change while a request is outstanding.
    assign imem_addr = pc;

    // Fetch sequencer: IDLE -> REQ -> HOLD -> (REQ | IDLE), outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_count <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    if (enable) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    // Stay here until memory answers; the wait is unbounded.
                    if (imem_ack) begin
                        state       <= HOLD;
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                    end
                end
                HOLD: begin
                    // Single-entry buffer: no new request until decode takes it.
                    if (instr_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + 8'd1;
                        if (enable) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a quiet IDLE.
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a driver plays memory and decode,
// a monitor checks each retired instruction against a scoreboard queue.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] next_pc;
    logic [7:0] pc;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] fetch_count;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (8),
        .RESET_PC    (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .next_pc     (next_pc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_count;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a retire is visible when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_retire", 32'(pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("retire_pc", 32'(pc), 32'(e.pc));
                chk("retire_instr", 32'(instr), 32'(e.instr));
                chk("retire_count", 32'(fetch_count), 32'(e.cnt));
            end
        end
    end

    // One complete fetch: wait for the request, ack after `waits` cycles,
    // hold off decode for `holds` cycles, then retire with next_pc = npc.
    task automatic fetch_one(input logic [7:0] addr, input logic [7:0] rdata,
                             input int waits, input int holds,
                             input logic [7:0] npc, output int lat);
        lat = 0;
        while (imem_req !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        if (imem_req !== 1'b1) return;
        chk("imem_addr", 32'(imem_addr), 32'(addr));
        for (int w = 0; w < waits; w++) begin
            @(posedge clk); #1;
            chk("req_wait", 32'(imem_req), 32'd1);
            chk("addr_stable", 32'(imem_addr), 32'(addr));
            chk("valid_wait", 32'(instr_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        sb.push_back('{pc: addr, instr: rdata, cnt: exp_count});
        exp_count++;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        chk("req_drop", 32'(imem_req), 32'd0);
        chk("valid_set", 32'(instr_valid), 32'd1);
        for (int h = 0; h < holds; h++) begin
            // A stray ack while holding must not overwrite the buffer.
            imem_ack   = 1'b1;
            imem_rdata = ~rdata;
            @(posedge clk); #1;
            imem_ack   = 1'b0;
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", 32'(instr), 32'(rdata));
            chk("hold_pc", 32'(pc), 32'(addr));
            chk("hold_req", 32'(imem_req), 32'd0);
        end
        next_pc     = npc;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("retire_next_pc", 32'(pc), 32'(npc));
        chk("retire_valid_clr", 32'(instr_valid), 32'd0);
    endtask

    int lat;

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        next_pc     = 8'h00;
        imem_ack    = 1'b0;
        imem_rdata  = 8'h00;
        instr_ready = 1'b0;
        exp_count   = 8'h00;

        // 1: reset state and start-up
        #3;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'h00);
        chk("rst_count", 32'(fetch_count), 32'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        chk("start_req", 32'(imem_req), 32'd1);
        chk("start_addr", 32'(imem_addr), 32'h00);

        // 2: zero-wait fetches, back to back
        fetch_one(8'h00, 8'hA5, 0, 0, 8'h01, lat);
        chk("lat_first", 32'(lat), 32'd0);
        fetch_one(8'h01, 8'h3C, 0, 0, 8'h02, lat);
        chk("lat_back_to_back", 32'(lat), 32'd0);

        // 3: wait states plus backpressure
        fetch_one(8'h02, 8'h7E, 3, 4, 8'h03, lat);

        // 4: jump
        fetch_one(8'h03, 8'h11, 1, 0, 8'hE3, lat);
        fetch_one(8'hE3, 8'h22, 0, 0, 8'hE4, lat);
        chk("jump_count", 32'(fetch_count), 32'(exp_count));

        // 5: stop while a request is outstanding
        enable = 1'b0;
        fetch_one(8'hE4, 8'h99, 2, 0, 8'hE5, lat);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("idle_req", 32'(imem_req), 32'd0);
            chk("idle_valid", 32'(instr_valid), 32'd0);
            chk("idle_pc", 32'(pc), 32'hE5);
        end
        imem_ack   = 1'b1;
        imem_rdata = 8'h55;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("idle_ack_ignored", 32'(instr_valid), 32'd0);
        chk("idle_ready_ignored", 32'(fetch_count), 32'(exp_count));
        enable = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_valid", 32'(instr_valid), 32'd0);
        chk("restart_pc", 32'(pc), 32'hE5);
        chk("restart_count", 32'(fetch_count), 32'(exp_count));
        fetch_one(8'hE5, 8'h0F, 0, 0, 8'hE6, lat);

        // 6: asynchronous reset while holding an instruction
        imem_ack   = 1'b1;
        imem_rdata = 8'h44;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        #2;
        rst_n     = 1'b0;
        exp_count = 8'h00;
        #1;
        chk("arst_pc", 32'(pc), 32'h00);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", 32'(instr), 32'h00);
        chk("arst_count", 32'(fetch_count), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerun_req", 32'(imem_req), 32'd1);

        // reset mid-request, then a late ack
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("arst_req_drop", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 8'h66;
        repeat (2) @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        chk("late_ack_instr", 32'(instr), 32'h00);
        chk("late_ack_req", 32'(imem_req), 32'd0);

        // fetch_count wraps after 256 retires
        enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            fetch_one(a, a ^ 8'h5A, 0, 0, a + 8'd1, lat);
        end
        chk("wrap_count", 32'(fetch_count), 32'h00);
        chk("wrap_pc", 32'(pc), 32'h00);

        enable = 1'b0;
        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
